ex_mem_stage: RTL and testbench



---
 rtl/ex_mem_stage_pkg.sv | 31 +++
 rtl/ex_mem_stage_alu.sv | 54 +++++
 rtl/ex_mem_stage.sv | 102 ++++++++++
 tb/tb_ex_mem_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_stage_pkg.sv
// Shared constants for the execute / EX-MEM / data-memory slice:
// ALU opcodes, R-type funct codes, control-bit positions and memory depth.
package ex_mem_stage_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_OR    = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRL = 6'h02;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    localparam int CTRL_REGDST   = 8;
    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;

    localparam int DMEM_DEPTH = 256;

endpackage

// File: rtl/ex_mem_stage_alu.sv
// Execute-stage ALU with funct decode, zero flag and branch-target adder.
// Purely combinational (0-cycle latency); no flow control of its own.
module ex_alu
    import ex_mem_stage_pkg::*;
(
    input  logic [31:0] i_reg1,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_sign_ext,
    input  logic [31:0] i_next_pc,
    input  logic [4:0]  i_shamt,
    input  logic [5:0]  i_funct,
    input  logic        i_alu_src,
    input  logic [1:0]  i_aluop,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic [31:0] o_branch_target
);

    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_result;

    assign w_a = i_reg1;
    assign w_b = i_alu_src ? i_sign_ext : i_reg2;

    // Shifts always take reg2 as the source, independent of ALUSrc.
    always_comb begin
        w_result = '0;
        case (aluop_e'(i_aluop))
            ALUOP_ADD: w_result = w_a + w_b;
            ALUOP_SUB: w_result = w_a - w_b;
            ALUOP_OR:  w_result = w_a | w_b;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: w_result = w_a + w_b;
                    FUNCT_SUB: w_result = w_a - w_b;
                    FUNCT_AND: w_result = w_a & w_b;
                    FUNCT_OR:  w_result = w_a | w_b;
                    FUNCT_NOR: w_result = ~(w_a | w_b);
                    FUNCT_SLT: w_result = {31'b0, ($signed(w_a) < $signed(w_b))};
                    FUNCT_SLL: w_result = i_reg2 << i_shamt;
                    FUNCT_SRL: w_result = i_reg2 >> i_shamt;
                    default:   w_result = '0;
                endcase
            end
            default: w_result = '0;
        endcase
    end

    assign o_result        = w_result;
    assign o_zero          = (w_result == 32'd0);
    assign o_branch_target = i_next_pc + {i_sign_ext[29:0], 2'b00};

endmodule

// File: rtl/ex_mem_stage.sv
// Execute + EX/MEM register + 256x32 data memory; EX outputs 0-cycle, EX/MEM 1-cycle, i_hit=0 stalls.
// Define DMEM_ALIGN_CHECK_EN to flag misaligned accesses (o_mem_hit=0, write dropped, read 0).
module ex_mem_stage
    import ex_mem_stage_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_hit,
    input  logic [31:0] i_reg1,
    input  logic [31:0] i_reg2,
    input  logic [31:0] i_sign_ext,
    input  logic [31:0] i_next_pc,
    input  logic [4:0]  i_shamt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rt,
    input  logic [5:0]  i_funct,
    input  logic [8:0]  i_ctrl,
    output logic [31:0] o_alu_result,
    output logic        o_zero,
    output logic [31:0] o_branch_target,
    output logic        o_pc_src,
    output logic [8:0]  o_exmem_ctrl,
    output logic [4:0]  o_exmem_rd,
    output logic [31:0] o_exmem_result,
    output logic [31:0] o_exmem_data2,
    output logic [31:0] o_mem_out,
    output logic        o_mem_hit
);

    logic [31:0] w_alu_result;
    logic        w_zero;
    logic [4:0]  w_dest;
    logic [7:0]  w_idx;
    logic        w_misalign;
    logic        w_wr_en;

    logic [8:0]  r_ctrl;
    logic [4:0]  r_rd;
    logic [31:0] r_result;
    logic [31:0] r_data2;
    logic [31:0] r_mem [DMEM_DEPTH];

    ex_alu u_alu (
        .i_reg1          (i_reg1),
        .i_reg2          (i_reg2),
        .i_sign_ext      (i_sign_ext),
        .i_next_pc       (i_next_pc),
        .i_shamt         (i_shamt),
        .i_funct         (i_funct),
        .i_alu_src       (i_ctrl[CTRL_ALUSRC]),
        .i_aluop         (i_ctrl[1:0]),
        .o_result        (w_alu_result),
        .o_zero          (w_zero),
        .o_branch_target (o_branch_target)
    );

    assign w_dest       = i_ctrl[CTRL_REGDST] ? i_rd : i_rt;
    assign o_alu_result = w_alu_result;
    assign o_zero       = w_zero;
    assign o_pc_src     = i_ctrl[CTRL_BRANCH] & w_zero;

    // Reset wins over stall: all fields clear even when i_hit=0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ctrl   <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_data2  <= '0;
        end else if (i_hit) begin
            r_ctrl   <= i_ctrl;
            r_rd     <= w_dest;
            r_result <= w_alu_result;
            r_data2  <= i_reg2;
        end
    end

    assign w_idx = r_result[9:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = (r_ctrl[CTRL_MEMREAD] | r_ctrl[CTRL_MEMWRITE]) & (r_result[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_wr_en = r_ctrl[CTRL_MEMWRITE] & i_hit & i_rst_n & ~w_misalign;

    // Memory has no reset; its contents survive rst_n.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= r_data2;
        end
    end

    assign o_mem_out = (r_ctrl[CTRL_MEMREAD] && !w_misalign) ? r_mem[w_idx] : 32'd0;
    assign o_mem_hit = ~w_misalign;

    assign o_exmem_ctrl   = r_ctrl;
    assign o_exmem_rd     = r_rd;
    assign o_exmem_result = r_result;
    assign o_exmem_data2  = r_data2;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: ALU vector table, hand-written memory/stall/reset
// sequences, then randomized traffic against a word-array reference of the pipeline slice.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n, hit;
    logic [31:0] reg1, reg2, sign_ext, next_pc;
    logic [4:0]  shamt, rd, rt;
    logic [5:0]  funct;
    logic [8:0]  ctrl;
    logic [31:0] alu_result, branch_target, exmem_result, exmem_data2, mem_out;
    logic        zero, pc_src, mem_hit;
    logic [8:0]  exmem_ctrl;
    logic [4:0]  exmem_rd;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_hit(hit),
        .i_reg1(reg1), .i_reg2(reg2), .i_sign_ext(sign_ext), .i_next_pc(next_pc),
        .i_shamt(shamt), .i_rd(rd), .i_rt(rt), .i_funct(funct), .i_ctrl(ctrl),
        .o_alu_result(alu_result), .o_zero(zero), .o_branch_target(branch_target),
        .o_pc_src(pc_src), .o_exmem_ctrl(exmem_ctrl), .o_exmem_rd(exmem_rd),
        .o_exmem_result(exmem_result), .o_exmem_data2(exmem_data2),
        .o_mem_out(mem_out), .o_mem_hit(mem_hit)
    );

    typedef struct {
        logic        rst_n;
        logic        hit;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [31:0] sext;
        logic [31:0] npc;
        logic [4:0]  shamt;
        logic [4:0]  rd;
        logic [4:0]  rt;
        logic [5:0]  funct;
        logic [8:0]  ctrl;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] alu;
        logic        z;
        logic        ps;
        logic [31:0] bt;
    } vec_t;

    // Reference state: what the EX/MEM register and the memory should hold.
    logic        m_valid = 1'b0;
    logic [8:0]  m_ctrl;
    logic [4:0]  m_rd;
    logic [31:0] m_res, m_data2;
    logic [31:0] mmem [256];

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic in_t mkin(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] se,
                                 input logic [31:0] np, input logic [4:0] sh, input logic [5:0] fn,
                                 input logic [8:0] c);
        in_t v;
        v.rst_n = 1'b1; v.hit = 1'b1;
        v.reg1 = r1; v.reg2 = r2; v.sext = se; v.npc = np;
        v.shamt = sh; v.rd = 5'd3; v.rt = 5'd7; v.funct = fn; v.ctrl = c;
        return v;
    endfunction

    function automatic logic [31:0] ref_alu(input in_t v);
        logic [31:0] a, b;
        a = v.reg1;
        b = v.ctrl[7] ? v.sext : v.reg2;
        case (v.ctrl[1:0])
            2'd0: return a + b;
            2'd1: return a - b;
            2'd3: return a | b;
            default: begin
                case (v.funct)
                    6'h20: return a + b;
                    6'h22: return a - b;
                    6'h24: return a & b;
                    6'h25: return a | b;
                    6'h27: return ~(a | b);
                    6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h00: return v.reg2 << v.shamt;
                    6'h02: return v.reg2 >> v.shamt;
                    default: return 32'd0;
                endcase
            end
        endcase
    endfunction

    function automatic logic ref_misalign(input logic [8:0] c, input logic [31:0] addr);
        return ALIGN_CHK && (c[4] || c[3]) && (addr[1:0] != 2'b00);
    endfunction

    // Drive one EX-stage beat, check combinational outputs, clock it, check the register.
    task automatic cycle(input in_t v);
        logic [31:0] e_alu, e_mo;
        logic        e_mis;
        rst_n = v.rst_n; hit = v.hit;
        reg1 = v.reg1; reg2 = v.reg2; sign_ext = v.sext; next_pc = v.npc;
        shamt = v.shamt; rd = v.rd; rt = v.rt; funct = v.funct; ctrl = v.ctrl;
        #1;
        e_alu = ref_alu(v);
        chk("alu_result", alu_result, e_alu);
        chk("zero", 32'(zero), 32'(e_alu == 32'd0));
        chk("branch_target", branch_target, v.npc + v.sext * 32'd4);
        chk("pc_src", 32'(pc_src), 32'(v.ctrl[2] && (e_alu == 32'd0)));
        e_mis = m_valid && ref_misalign(m_ctrl, m_res);
        if (m_valid) begin
            e_mo = (m_ctrl[4] && !e_mis) ? mmem[m_res[9:2]] : 32'd0;
            chk("mem_out", mem_out, e_mo);
            chk("mem_hit", 32'(mem_hit), 32'(!e_mis));
        end
        @(posedge clk);
        if (m_valid && v.rst_n && v.hit && m_ctrl[3] && !e_mis)
            mmem[m_res[9:2]] = m_data2;
        if (!v.rst_n) begin
            m_ctrl = '0; m_rd = '0; m_res = '0; m_data2 = '0; m_valid = 1'b1;
        end else if (v.hit) begin
            m_ctrl = v.ctrl; m_rd = v.ctrl[8] ? v.rd : v.rt; m_res = e_alu; m_data2 = v.reg2;
        end
        #1;
        if (m_valid) begin
            chk("exmem_ctrl", 32'(exmem_ctrl), 32'(m_ctrl));
            chk("exmem_rd", 32'(exmem_rd), 32'(m_rd));
            chk("exmem_result", exmem_result, m_res);
            chk("exmem_data2", exmem_data2, m_data2);
        end
    endtask

    vec_t vecs[13];
    in_t  v;

    initial begin
        vecs[0]  = '{mkin(32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 6'h20, 9'h102), 32'd12, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{mkin(32'd9, 32'd9, 32'd3, 32'h100, 5'd0, 6'h00, 9'h005), 32'd0, 1'b1, 1'b1, 32'h10C};
        vecs[2]  = '{mkin(32'd9, 32'd8, 32'd3, 32'h100, 5'd0, 6'h00, 9'h005), 32'd1, 1'b0, 1'b0, 32'h10C};
        vecs[3]  = '{mkin(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 6'h2A, 9'h002), 32'd1, 1'b0, 1'b0, 32'd0};
        vecs[4]  = '{mkin(32'd0, 32'd1, 32'd0, 32'd0, 5'd4, 6'h00, 9'h002), 32'h10, 1'b0, 1'b0, 32'd0};
        vecs[5]  = '{mkin(32'd0, 32'h8000_0000, 32'd0, 32'd0, 5'd31, 6'h02, 9'h002), 32'd1, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{mkin(32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd0, 6'h24, 9'h002), 32'h0000_F000, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{mkin(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'h27, 9'h002), 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0};
        vecs[8]  = '{mkin(32'd3, 32'd5, 32'd0, 32'd0, 5'd0, 6'h22, 9'h002), 32'hFFFF_FFFE, 1'b0, 1'b0, 32'd0};
        vecs[9]  = '{mkin(32'd3, 32'd5, 32'd0, 32'd0, 5'd0, 6'h3F, 9'h006), 32'd0, 1'b1, 1'b1, 32'd0};
        vecs[10] = '{mkin(32'h0F00, 32'h1, 32'h00F0, 32'd0, 5'd0, 6'h00, 9'h083), 32'h0FF0, 1'b0, 1'b0, 32'h3C0};
        vecs[11] = '{mkin(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd0, 6'h00, 9'h000), 32'd0, 1'b1, 1'b0, 32'd0};
        vecs[12] = '{mkin(32'd1, 32'd2, 32'hFFFF_FFFF, 32'h100, 5'd0, 6'h25, 9'h002), 32'd3, 1'b0, 1'b0, 32'hFC};

        // Reset with stall asserted, then check the cleared register.
        v = mkin(32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 6'h20, 9'h1FF);
        v.rst_n = 1'b0; v.hit = 1'b0;
        cycle(v);
        chk("reset exmem_ctrl", 32'(exmem_ctrl), 32'd0);
        chk("reset exmem_result", exmem_result, 32'd0);
        chk("reset mem_out", mem_out, 32'd0);
        chk("reset mem_hit", 32'(mem_hit), 32'd1);

        // Store zeros to every word so the reference and the array agree.
        for (int i = 0; i < 256; i++) cycle(mkin(32'd0, 32'd0, 32'(i * 4), 32'd0, 5'd0, 6'h00, 9'h088));
        cycle(mkin(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 9'h000));

        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].in);
            rst_n = 1'b1; hit = 1'b0;
            reg1 = vecs[i].in.reg1; reg2 = vecs[i].in.reg2; sign_ext = vecs[i].in.sext;
            next_pc = vecs[i].in.npc; shamt = vecs[i].in.shamt; funct = vecs[i].in.funct;
            ctrl = vecs[i].in.ctrl;
            #1;
            chk($sformatf("vec%0d alu_result", i), alu_result, vecs[i].alu);
            chk($sformatf("vec%0d zero", i), 32'(zero), 32'(vecs[i].z));
            chk($sformatf("vec%0d pc_src", i), 32'(pc_src), 32'(vecs[i].ps));
            chk($sformatf("vec%0d branch_target", i), branch_target, vecs[i].bt);
            @(negedge clk);
        end

        // Add lands in EX/MEM with rd selected.
        cycle(mkin(32'd5, 32'd7, 32'd0, 32'd0, 5'd0, 6'h20, 9'h102));
        chk("add exmem_result", exmem_result, 32'd12);
        chk("add exmem_rd", 32'(exmem_rd), 32'd3);

        // Store then load the same address.
        cycle(mkin(32'h10, 32'hDEAD_BEEF, 32'd4, 32'd0, 5'd0, 6'h00, 9'h088));
        cycle(mkin(32'h10, 32'd0, 32'd4, 32'd0, 5'd0, 6'h00, 9'h090));
        chk("load mem_out", mem_out, 32'hDEAD_BEEF);

        // Pending store held through two stalls, then killed by reset under stall.
        cycle(mkin(32'h20, 32'h1234_5678, 32'd0, 32'd0, 5'd0, 6'h00, 9'h088));
        for (int i = 0; i < 2; i++) begin
            v = mkin(32'h30, 32'h5555_AAAA, 32'd0, 32'd0, 5'd0, 6'h00, 9'h090);
            v.hit = 1'b0;
            cycle(v);
            chk("stall exmem_ctrl", 32'(exmem_ctrl), 32'h088);
            chk("stall exmem_result", exmem_result, 32'h20);
            chk("stall exmem_data2", exmem_data2, 32'h1234_5678);
        end
        v.rst_n = 1'b0; v.hit = 1'b0;
        cycle(v);
        chk("rst exmem_ctrl", 32'(exmem_ctrl), 32'd0);
        chk("rst exmem_rd", 32'(exmem_rd), 32'd0);
        chk("rst exmem_result", exmem_result, 32'd0);
        chk("rst exmem_data2", exmem_data2, 32'd0);
        chk("rst mem_out", mem_out, 32'd0);
        cycle(mkin(32'h20, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 9'h090));
        chk("stalled store not written", mem_out, 32'd0);

        // Misaligned store to 0x13, then aligned and misaligned loads of word 4.
        cycle(mkin(32'h10, 32'hA5A5_A5A5, 32'd3, 32'd0, 5'd0, 6'h00, 9'h088));
        chk("misaligned store mem_hit", 32'(mem_hit), ALIGN_CHK ? 32'd0 : 32'd1);
        cycle(mkin(32'h10, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 9'h090));
        chk("word4 after misaligned store", mem_out, ALIGN_CHK ? 32'd0 : 32'hA5A5_A5A5);
        cycle(mkin(32'h10, 32'd0, 32'd3, 32'd0, 5'd0, 6'h00, 9'h090));
        chk("misaligned load mem_out", mem_out, ALIGN_CHK ? 32'd0 : 32'hA5A5_A5A5);
        chk("misaligned load mem_hit", 32'(mem_hit), ALIGN_CHK ? 32'd0 : 32'd1);

        // Randomized traffic; addresses biased into a small window so loads hit stored words.
        for (int i = 0; i < 600; i++) begin
            v = mkin($urandom, $urandom, $urandom, $urandom, 5'($urandom), 6'($urandom), 9'($urandom));
            v.rd = 5'($urandom); v.rt = 5'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                v.reg1 = 32'($urandom_range(0, 63));
                v.sext = 32'($urandom_range(0, 15)) & ((ALIGN_CHK && $urandom_range(0, 3) == 0) ? 32'hF : 32'hC);
                v.ctrl[1:0] = 2'b00;
                v.ctrl[7] = 1'b1;
                if (v.reg1[1:0] != 0 && $urandom_range(0, 3) != 0) v.reg1[1:0] = 2'b00;
            end
            v.hit   = ($urandom_range(0, 7) != 0);
            v.rst_n = ($urandom_range(0, 59) != 0);
            cycle(v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
